// File: rtl/vexec_pkg.sv
// Shared definitions for the vector execution unit: opcodes, FSM states and the legality check.
// Defining VEXEC_MUL_EN makes opcode 11 (MUL) legal; otherwise it takes the illegal-op path.
package vexec_pkg;

    localparam logic [3:0] VOP_ADD = 4'd0;
    localparam logic [3:0] VOP_SUB = 4'd1;
    localparam logic [3:0] VOP_AND = 4'd2;
    localparam logic [3:0] VOP_OR  = 4'd3;
    localparam logic [3:0] VOP_XOR = 4'd4;
    localparam logic [3:0] VOP_SLL = 4'd5;
    localparam logic [3:0] VOP_SRL = 4'd6;
    localparam logic [3:0] VOP_SRA = 4'd7;
    localparam logic [3:0] VOP_SLT = 4'd8;
    localparam logic [3:0] VOP_MIN = 4'd9;
    localparam logic [3:0] VOP_MAX = 4'd10;
    localparam logic [3:0] VOP_MUL = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WB   = 2'd2
    } vexec_state_t;

    function automatic logic vop_legal(input logic [3:0] op);
`ifdef VEXEC_MUL_EN
        return op <= VOP_MUL;
`else
        return op < VOP_MUL;
`endif
    endfunction

endpackage

// File: rtl/vexec_lane_alu.sv
// Combinational single-element ALU used once per cycle by vexec_unit.
// The multiplier exists only when VEXEC_MUL_EN is defined.
module vexec_lane_alu
    import vexec_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    localparam int SH_W = $clog2(W);

    logic [SH_W-1:0] shamt;
    logic            lt_signed;

    assign shamt     = b[SH_W-1:0];
    assign lt_signed = $signed(a) < $signed(b);

    always_comb begin
        y = '0;
        case (op)
            VOP_ADD: y = a + b;
            VOP_SUB: y = a - b;
            VOP_AND: y = a & b;
            VOP_OR:  y = a | b;
            VOP_XOR: y = a ^ b;
            VOP_SLL: y = a << shamt;
            VOP_SRL: y = a >> shamt;
            VOP_SRA: y = $signed(a) >>> shamt;
            VOP_SLT: y = {{(W-1){1'b0}}, lt_signed};
            VOP_MIN: y = lt_signed ? a : b;
            VOP_MAX: y = lt_signed ? b : a;
`ifdef VEXEC_MUL_EN
            VOP_MUL: y = a * b;
`endif
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vexec_unit.sv
// Multi-cycle vector execution unit: captures two vectors, computes one element per cycle,
// then issues one full-vector register-file write. MUL support is gated by VEXEC_MUL_EN.
module vexec_unit
    import vexec_pkg::*;
#(
    parameter int ELEMENTS_PER_REGISTER = 4,
    parameter int ELEM_WIDTH            = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic [3:0]                                op,
    input  logic [4:0]                                vd,
    input  logic [ELEM_WIDTH*ELEMENTS_PER_REGISTER-1:0] va,
    input  logic [ELEM_WIDTH*ELEMENTS_PER_REGISTER-1:0] vb,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      illegal,
    output logic                                      we3,
    output logic [4:0]                                a3,
    output logic [ELEM_WIDTH*ELEMENTS_PER_REGISTER-1:0] wd3
);

    localparam int N     = ELEMENTS_PER_REGISTER;
    localparam int W     = ELEM_WIDTH;
    localparam int IDX_W = $clog2(N);

    vexec_state_t state, next_state;

    logic [IDX_W-1:0] idx;
    logic [3:0]       op_q;
    logic [4:0]       vd_q;
    logic [W*N-1:0]   va_q;
    logic [W*N-1:0]   vb_q;
    logic [W*N-1:0]   result_q;
    logic [W-1:0]     elem_a;
    logic [W-1:0]     elem_b;
    logic [W-1:0]     elem_y;
    logic             last_elem;
    logic             accept;

    assign accept    = (state == ST_IDLE) && start;
    assign last_elem = (idx == IDX_W'(N - 1));
    assign elem_a    = va_q[idx*W +: W];
    assign elem_b    = vb_q[idx*W +: W];

    vexec_lane_alu #(
        .W (W)
    ) u_lane_alu (
        .op (op_q),
        .a  (elem_a),
        .b  (elem_b),
        .y  (elem_y)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Outputs decode from the registered state so write-back signals hold for the whole WB cycle.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        we3        = 1'b0;
        a3         = '0;
        wd3        = '0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = vop_legal(op) ? ST_BUSY : ST_WB;
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (last_elem) next_state = ST_WB;
            end
            ST_WB: begin
                busy       = 1'b1;
                done       = 1'b1;
                illegal    = !vop_legal(op_q);
                we3        = vop_legal(op_q) && (vd_q != 5'd0);
                a3         = vd_q;
                wd3        = result_q;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Operand capture happens only on accept; later input changes are never seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= '0;
            op_q     <= '0;
            vd_q     <= '0;
            va_q     <= '0;
            vb_q     <= '0;
            result_q <= '0;
        end else if (accept) begin
            idx  <= '0;
            op_q <= op;
            vd_q <= vd;
            va_q <= va;
            vb_q <= vb;
        end else if (state == ST_BUSY) begin
            result_q[idx*W +: W] <= elem_y;
            if (!last_elem) idx <= idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_vexec_unit.sv
// Directed self-checking bench for vexec_unit (N=4, W=32) with hand-computed vectors.
// Builds with or without VEXEC_MUL_EN; the MUL expectations follow the macro.
module tb_vexec_unit;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [4:0]   vd;
    logic [127:0] va;
    logic [127:0] vb;
    logic         busy;
    logic         done;
    logic         illegal;
    logic         we3;
    logic [4:0]   a3;
    logic [127:0] wd3;

    int checks = 0;
    int errors = 0;

    vexec_unit #(
        .ELEMENTS_PER_REGISTER (4),
        .ELEM_WIDTH            (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .vd      (vd),
        .va      (va),
        .vb      (vb),
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .we3     (we3),
        .a3      (a3),
        .wd3     (wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] vec4(input logic [31:0] e3, input logic [31:0] e2,
                                          input logic [31:0] e1, input logic [31:0] e0);
        return {e3, e2, e1, e0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accepts one op, scrambles the inputs, and returns with the bench sitting in the done cycle.
    task automatic run_op(input logic [3:0] o, input logic [4:0] d,
                          input logic [127:0] a, input logic [127:0] b, output int lat);
        op = o; vd = d; va = a; vb = b; start = 1'b1;
        tick();
        start = 1'b0; op = 4'hD; vd = 5'd31; va = '1; vb = '1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            tick();
        end
    endtask

    task automatic do_vec(input string tag, input logic [3:0] o, input logic [4:0] d,
                          input logic [127:0] a, input logic [127:0] b, input logic [127:0] exp);
        int lat;
        run_op(o, d, a, b, lat);
        check({tag, "_lat"}, 128'(lat), 128'd5);
        check({tag, "_we3"}, 128'(we3), 128'd1);
        check({tag, "_a3"}, 128'(a3), 128'(d));
        check({tag, "_wd3"}, wd3, exp);
        tick();
    endtask

    initial begin
        int lat;
        int we_count;
        logic [127:0] sa, sb;

        reset = 1'b1; start = 1'b0; op = '0; vd = '0; va = '0; vb = '0;
        tick();
        tick();
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_illegal", 128'(illegal), 128'd0);
        check("rst_we3", 128'(we3), 128'd0);
        check("rst_a3", 128'(a3), 128'd0);
        check("rst_wd3", wd3, 128'd0);
        reset = 1'b0;
        tick();

        // ADD with cycle-by-cycle busy checks; inputs change right after accept
        op = 4'd0; vd = 5'd5; va = vec4(4, 3, 2, 1); vb = vec4(40, 30, 20, 10); start = 1'b1;
        tick();
        start = 1'b0; op = 4'd1; va = vec4(9, 9, 9, 9); vb = vec4(9, 9, 9, 9);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("add_busy%0d", k), 128'(busy), 128'd1);
            check($sformatf("add_done%0d", k), 128'(done), 128'd0);
            check($sformatf("add_we3_%0d", k), 128'(we3), 128'd0);
            tick();
        end
        check("add_done", 128'(done), 128'd1);
        check("add_busy_wb", 128'(busy), 128'd1);
        check("add_we3", 128'(we3), 128'd1);
        check("add_a3", 128'(a3), 128'd5);
        check("add_wd3", wd3, vec4(44, 33, 22, 11));
        check("add_illegal", 128'(illegal), 128'd0);
        tick();
        check("add_idle_busy", 128'(busy), 128'd0);
        check("add_idle_done", 128'(done), 128'd0);
        check("add_idle_we3", 128'(we3), 128'd0);
        check("add_idle_wd3", wd3, 128'd0);

        do_vec("sub", 4'd1, 5'd1, vec4(32'h80000000, 5, 100, 0), vec4(1, 5, 7, 1),
               vec4(32'h7FFFFFFF, 0, 93, 32'hFFFFFFFF));
        do_vec("min", 4'd9, 5'd2, vec4(2, 7, 5, 32'hFFFFFFFF), vec4(3, 7, 32'h80000000, 1),
               vec4(2, 7, 32'h80000000, 32'hFFFFFFFF));
        do_vec("sra", 4'd7, 5'd3, vec4(1, 32'hFFFFFFFF, 32'h7FFFFFF0, 32'h80000000), vec4(0, 31, 4, 35),
               vec4(1, 32'hFFFFFFFF, 32'h07FFFFFF, 32'hF0000000));
        do_vec("slt", 4'd8, 5'd4, vec4(32'h80000000, 5, 1, 32'hFFFFFFFF), vec4(32'h7FFFFFFF, 5, 32'hFFFFFFFF, 1),
               vec4(1, 0, 0, 1));

        sa = vec4(32'h0000FFFF, 32'hF0F0F0F0, 32'h80000001, 32'h12345678);
        sb = vec4(32'h0000001F, 32'h0F0F0F08, 32'h00000021, 32'h00000004);
        do_vec("and", 4'd2, 5'd6, sa, sb, vec4(32'h1F, 0, 1, 0));
        do_vec("or", 4'd3, 5'd7, sa, sb, vec4(32'h0000FFFF, 32'hFFFFFFF8, 32'h80000021, 32'h1234567C));
        do_vec("xor", 4'd4, 5'd8, sa, sb, vec4(32'h0000FFE0, 32'hFFFFFFF8, 32'h80000020, 32'h1234567C));
        do_vec("sll", 4'd5, 5'd9, sa, sb, vec4(32'h80000000, 32'hF0F0F000, 32'h00000002, 32'h23456780));
        do_vec("srl", 4'd6, 5'd10, sa, sb, vec4(0, 32'h00F0F0F0, 32'h40000000, 32'h01234567));
        do_vec("max", 4'd10, 5'd11, sa, sb, vec4(32'h0000FFFF, 32'h0F0F0F08, 32'h21, 32'h12345678));

        // vd=0 completes without writing
        run_op(4'd0, 5'd0, vec4(1, 1, 1, 1), vec4(1, 1, 1, 1), lat);
        check("vd0_lat", 128'(lat), 128'd5);
        check("vd0_we3", 128'(we3), 128'd0);
        check("vd0_a3", 128'(a3), 128'd0);
        tick();

        // Illegal op, with start held through WB: accepted only at the IDLE edge
        run_op(4'd14, 5'd3, vec4(5, 5, 5, 5), vec4(5, 5, 5, 5), lat);
        check("ill_lat", 128'(lat), 128'd1);
        check("ill_illegal", 128'(illegal), 128'd1);
        check("ill_we3", 128'(we3), 128'd0);
        op = 4'd0; vd = 5'd2; va = vec4(1, 1, 1, 1); vb = vec4(2, 2, 2, 2); start = 1'b1;
        tick();
        check("ill_next_idle", 128'(busy), 128'd0);
        tick();
        start = 1'b0;
        check("ill_next_busy", 128'(busy), 128'd1);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            tick();
        end
        check("ill_next_lat", 128'(lat), 128'd5);
        check("ill_next_a3", 128'(a3), 128'd2);
        check("ill_next_wd3", wd3, vec4(3, 3, 3, 3));
        tick();

        // start pulses during BUSY and WB with other operands must be ignored
        op = 4'd0; vd = 5'd7; va = vec4(400, 300, 200, 100); vb = vec4(1, 1, 1, 1); start = 1'b1;
        tick();
        op = 4'd1; vd = 5'd9; va = vec4(8, 8, 8, 8); vb = vec4(3, 3, 3, 3);
        for (int k = 1; k <= 4; k++) tick();
        check("ign_done", 128'(done), 128'd1);
        check("ign_a3", 128'(a3), 128'd7);
        check("ign_wd3", wd3, vec4(401, 301, 201, 101));
        tick();
        start = 1'b0;
        check("ign_wb_start", 128'(busy), 128'd0);
        tick();

        // Reset mid-operation discards it, and wins over a concurrent start
        op = 4'd0; vd = 5'd12; va = vec4(1, 2, 3, 4); vb = vec4(1, 2, 3, 4); start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        check("rst_mid_busy", 128'(busy), 128'd0);
        check("rst_mid_done", 128'(done), 128'd0);
        we_count = 0;
        for (int k = 0; k < 8; k++) begin
            if (we3 === 1'b1) we_count++;
            tick();
        end
        check("rst_mid_no_we3", 128'(we_count), 128'd0);

`ifdef VEXEC_MUL_EN
        do_vec("mul", 4'd11, 5'd13, vec4(32'hFFFFFFFF, 7, 32'h10000, 3),
               vec4(32'hFFFFFFFF, 6, 32'h10000, 32'hFFFFFFFE),
               vec4(1, 42, 0, 32'hFFFFFFFA));
`else
        run_op(4'd11, 5'd13, vec4(32'hFFFFFFFF, 7, 32'h10000, 3),
               vec4(32'hFFFFFFFF, 6, 32'h10000, 32'hFFFFFFFE), lat);
        check("mul_ill_lat", 128'(lat), 128'd1);
        check("mul_ill_illegal", 128'(illegal), 128'd1);
        check("mul_ill_we3", 128'(we3), 128'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vexec_unit.md
# vexec_unit

Multi-cycle vector execution unit between the vector register file's read ports and its write port. It captures two full vector operands and an opcode, and processes one element per cycle, element 0 first. When all elements are done it issues a single full-vector write-back (`we3`/`a3`/`wd3`) to the register file. It is the consumer of `rd1`/`rd2` and the sole producer of the vector write port.

## Interface
- `ELEMENTS_PER_REGISTER`, default 4: elements per vector (N), N ≥ 2.
- `ELEM_WIDTH`, default 32: bits per element (W), a power of two ≥ 8.
- `clk`, input, 1: clock. All state updates on rising edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: request. Accepted only when in IDLE.
- `op`, input, 4: opcode, sampled at accept.
- `vd`, input, 5: destination register, sampled at accept.
- `va`, input, W*N: operand A. Element i is `[i*W +: W]`.
- `vb`, input, W*N: operand B, same layout as `va`.
- `busy`, output, 1: high from the cycle after accept through the WB cycle.
- `done`, output, 1: one-cycle pulse in the WB cycle.
- `illegal`, output, 1: high with `done` when the opcode was unsupported.
- `we3`, output, 1: register-file write enable.
- `a3`, output, 5: register-file write address.
- `wd3`, output, W*N: register-file write data.

## Operation
- States:
  - IDLE: `start` high → capture `op`, `vd`, `va`, `vb` into internal registers and clear the element index.
    - Legal op → BUSY.
    - Illegal op → WB.
  - BUSY: compute element `idx` from the captured operands and store it in the result register.
    - `idx` == N−1 → WB.
    - Otherwise `idx`+1.
  - WB: drive `done`=1, `busy`=1, `a3`=vd, `wd3`=result, `illegal` per op. Always → IDLE.
- `we3` = 1 in WB only when op is legal and vd ≠ 0. `vd`=0 completes with `done` but performs no write.
- Outside WB, `we3`=0, `a3`=0, `wd3`=0, `done`=0, `illegal`=0.
- Inputs may change freely after accept; only captured copies are used.
- `start` is ignored while `busy`=1, including the WB cycle. No queuing.
- Opcodes:
  - 0 ADD, 1 SUB: modulo 2^W.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount is `b[log2(W)-1:0]`.
  - 8 SLT: signed, result 1/0 zero-extended.
  - 9 MIN, 10 MAX: signed.
  - 11 MUL: low W bits, see Configuration.
  - 12–15 illegal.
- Reset values: state IDLE, index 0, result 0, and every output 0.

## Timing
- Accept at edge T (IDLE, `start`=1).
- BUSY covers cycles T+1..T+N. Element i is written at the end of cycle T+1+i.
- WB is cycle T+N+1, with `done`/`we3` high. Back in IDLE at T+N+2.
- The earliest next accept is the edge ending cycle T+N+2. Throughput is one op per N+2 cycles.
- Illegal op: WB at T+1, IDLE at T+2.
- `we3`/`a3`/`wd3` are stable for the whole WB cycle, so the register file's falling-edge write samples them mid-cycle.
- `reset` asserted in any state: next cycle is IDLE with all outputs 0. An in-flight op is discarded and no write is issued. Reset takes priority over `start`.

## Configuration
- `VEXEC_MUL_EN` defined: opcode 11 is legal and produces a W×W multiply, low W bits. The multiplier is combinational inside the lane ALU, one element per cycle.
- `VEXEC_MUL_EN` undefined: opcode 11 is illegal and takes the illegal path (WB at T+1, `illegal`=1, `we3`=0). No multiplier is synthesised.

## Structure
- Package `vexec_pkg`:
  - opcode localparams (`VOP_ADD`..`VOP_MUL`);
  - state encoding (IDLE/BUSY/WB);
  - function `vop_legal(op)` honouring `VEXEC_MUL_EN`.
- Sub-module `vexec_lane_alu`: combinational single-element ALU with inputs (op, a[W], b[W]) and output y[W]. The top level holds the FSM, index counter, operand/result registers and element muxing.

## Test plan
- ADD, vd=5, a={1,2,3,4}, b={10,20,30,40} (e0 first) → at T+5: `done`=1, `we3`=1, `a3`=5, `wd3`={11,22,33,44}; `busy` high T+1..T+5.
- SUB/MIN/SRA: a e0=0, b e0=1 → SUB e0=0xFFFFFFFF. MIN(0xFFFFFFFF,1) → 0xFFFFFFFF. SRA(0x80000000, 35) → 0xF0000000 (shift amount 3).
- vd=0 with ADD → `done`=1 at T+5, `we3`=0, `a3`=0.
- op=14 → `done`=1 and `illegal`=1 at T+1, `we3`=0. Next `start` is accepted at T+2.
- `start` pulsed during BUSY and WB with different operands → ignored, original result written. Separately, `reset` at T+2 → `busy`=0 at T+3, no `we3` ever.
- MUL with `VEXEC_MUL_EN`: e0 3×0xFFFFFFFE → 0xFFFFFFFA; e1 0x10000×0x10000 → 0. Without the macro → illegal path.
